// File: rtl/recv_board_if.sv
// Host-side bundle for recv_board: the start handshake, the UART byte
// stream and the parsed board result.
interface recv_board_if #(
    parameter int ROWS = 3,
    parameter int COLS = 3
);
    logic                   req;
    logic                   ready;
    logic                   uart_rd;
    logic [7:0]             uart_q;
    logic [ROWS*COLS-1:0]   board_a_out;
    logic [ROWS*COLS-1:0]   board_b_out;
    logic                   valid;
    logic                   error_flag;

    modport master (
        output req, uart_rd, uart_q,
        input  ready, board_a_out, board_b_out, valid, error_flag
    );

    modport slave (
        input  req, uart_rd, uart_q,
        output ready, board_a_out, board_b_out, valid, error_flag
    );
endinterface

// File: rtl/recv_board.sv
// recv_board: parses a ROWS-line text board image ("O", "X", "." cells,
// spaces/bars/CR ignored, LF ends a row) arriving from uart_rx and
// publishes the result as two bitmaps with a one-cycle valid pulse.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready=1, waiting for req; bytes are ignored
//   RECV  | accumulating cells into row/col
//   SKIP  | frame already bad, discard bytes up to the next LF
//   CHECK | frame complete, compare O/X counts
//   DONE  | valid pulse is out, return to IDLE
module recv_board #(
    parameter int ROWS = 3,
    parameter int COLS = 3
) (
    input  logic        clk,
    input  logic        reset,
    recv_board_if.slave host
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam int IW = $clog2(N + 1);
    // One spare bit so popcount+1 never wraps.
    localparam int PW = $clog2(N + 2);

    localparam logic [CW-1:0] COL_FULL = CW'(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    localparam logic [7:0] CH_O   = 8'h4F;
    localparam logic [7:0] CH_X   = 8'h58;
    localparam logic [7:0] CH_DOT = 8'h2E;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_BAR = 8'h7C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;

    typedef enum logic [2:0] {IDLE, RECV, SKIP, CHECK, DONE} state_t;

    state_t          state_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [N-1:0]    acc_a_q;
    logic [N-1:0]    acc_b_q;
    logic [N-1:0]    board_a_q;
    logic [N-1:0]    board_b_q;
    logic            ready_q;
    logic            valid_q;
    logic            error_q;

    logic            is_cell;
    logic            is_lf;
    logic            is_ign;
    logic [IW-1:0]   cell_idx;
    logic [N-1:0]    cell_mask;
    logic [PW-1:0]   pop_a;
    logic [PW-1:0]   pop_b;
    logic            count_bad;

    function automatic logic [PW-1:0] popcount(input logic [N-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < N; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    // Byte classification, target cell of the current byte and the O/X balance test.
    always_comb begin
        is_cell   = (host.uart_q == CH_O) || (host.uart_q == CH_X) || (host.uart_q == CH_DOT);
        is_lf     = (host.uart_q == CH_LF);
        is_ign    = (host.uart_q == CH_SP) || (host.uart_q == CH_BAR) || (host.uart_q == CH_CR);
        cell_idx  = IW'(row_q) * IW'(COLS) + IW'(col_q);
        cell_mask = {{(N-1){1'b0}}, 1'b1} << cell_idx;
        pop_a     = popcount(acc_a_q);
        pop_b     = popcount(acc_b_q);
        count_bad = (pop_a > pop_b + PW'(1)) || (pop_b > pop_a + PW'(1));
    end

    // Parser FSM; all outputs are registered here and only move on DONE entry,
    // on reset, or (error_flag) when a req is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            board_a_q <= '0;
            board_b_q <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (host.req) begin
                        state_q <= RECV;
                        ready_q <= 1'b0;
                        acc_a_q <= '0;
                        acc_b_q <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        error_q <= 1'b0;
                    end
                end
                RECV: begin
                    if (host.uart_rd) begin
                        if (is_cell) begin
                            if (col_q == COL_FULL) begin
                                state_q <= SKIP;
                            end else begin
                                if (host.uart_q == CH_O) acc_a_q <= acc_a_q | cell_mask;
                                if (host.uart_q == CH_X) acc_b_q <= acc_b_q | cell_mask;
                                col_q <= col_q + CW'(1);
                            end
                        end else if (is_lf) begin
                            if (col_q == COL_FULL) begin
                                col_q <= '0;
                                row_q <= row_q + RW'(1);
                                if (row_q == ROW_LAST) state_q <= CHECK;
                            end else if (col_q != '0) begin
                                // Short row: the LF itself ends the frame.
                                state_q   <= DONE;
                                valid_q   <= 1'b1;
                                error_q   <= 1'b1;
                                board_a_q <= '0;
                                board_b_q <= '0;
                            end
                        end else if (!is_ign) begin
                            state_q <= SKIP;
                        end
                    end
                end
                SKIP: begin
                    if (host.uart_rd && is_lf) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b1;
                        error_q   <= 1'b1;
                        board_a_q <= '0;
                        board_b_q <= '0;
                    end
                end
                CHECK: begin
                    state_q <= DONE;
                    valid_q <= 1'b1;
                    if (count_bad) begin
                        error_q   <= 1'b1;
                        board_a_q <= '0;
                        board_b_q <= '0;
                    end else begin
                        board_a_q <= acc_a_q;
                        board_b_q <= acc_b_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign host.ready       = ready_q;
    assign host.valid       = valid_q;
    assign host.error_flag  = error_q;
    assign host.board_a_out = board_a_q;
    assign host.board_b_out = board_b_q;
endmodule

// File: tb/tb_recv_board.sv
// Bench for recv_board: directed frames plus random frames, each compared
// with a line-oriented reference parser.
module tb_recv_board;
    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;

    typedef logic [7:0] u8;
    typedef u8 bq_t[$];

    localparam u8 CH_O   = 8'h4F;
    localparam u8 CH_X   = 8'h58;
    localparam u8 CH_DOT = 8'h2E;
    localparam u8 CH_SP  = 8'h20;
    localparam u8 CH_BAR = 8'h7C;
    localparam u8 CH_CR  = 8'h0D;
    localparam u8 CH_LF  = 8'h0A;
    localparam u8 CH_BAD = 8'h5A;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    recv_board_if #(.ROWS(ROWS), .COLS(COLS)) host ();
    recv_board #(.ROWS(ROWS), .COLS(COLS)) dut (.clk(clk), .reset(reset), .host(host));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Valid-pulse monitor: counts pulses and captures the result.
    int vcount = 0;
    int v_cyc = 0;
    logic [N-1:0] v_a = '0;
    logic [N-1:0] v_b = '0;
    logic v_err = 1'b0;
    always @(negedge clk) begin
        if (host.valid) begin
            vcount++;
            v_cyc = cyc;
            v_a   = host.board_a_out;
            v_b   = host.board_b_out;
            v_err = host.error_flag;
        end
    end

    logic [N-1:0] last_a = '0;
    logic [N-1:0] last_b = '0;
    logic last_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
        return q;
    endfunction

    // Reference: split the stream into lines; a line is blank, a full row,
    // or a fault (bad byte, too few or too many cells) that ends the frame.
    function automatic void model(input bq_t q, output int term, output bit full,
                                  output bit err, output logic [N-1:0] a, output logic [N-1:0] b);
        u8 cells[$];
        bit bad;
        int rows;
        int na;
        int nb;
        term = -1; full = 0; err = 0; a = '0; b = '0; bad = 0; rows = 0;
        foreach (q[i]) begin
            u8 c;
            c = q[i];
            if (c == CH_O || c == CH_X || c == CH_DOT) begin
                cells.push_back(c);
            end else if (c == CH_LF) begin
                if (bad || cells.size() > COLS || (cells.size() > 0 && cells.size() < COLS)) begin
                    err = 1; term = i; return;
                end
                if (cells.size() == COLS) begin
                    foreach (cells[j]) begin
                        if (cells[j] == CH_O) a[rows*COLS + j] = 1'b1;
                        if (cells[j] == CH_X) b[rows*COLS + j] = 1'b1;
                    end
                    rows++;
                    cells.delete();
                    if (rows == ROWS) begin
                        term = i; full = 1;
                        na = $countones(a);
                        nb = $countones(b);
                        if (na - nb > 1 || nb - na > 1) err = 1;
                        return;
                    end
                end
            end else if (!(c == CH_SP || c == CH_BAR || c == CH_CR)) begin
                bad = 1;
            end
        end
    endfunction

    function automatic bq_t gen_frame();
        bq_t q;
        int len;
        int k;
        int sel;
        for (int r = 0; r < ROWS; r++) begin
            if ($urandom_range(0, 9) == 0) q.push_back(CH_LF);
            k = $urandom_range(0, 19);
            if (k == 0)      len = $urandom_range(1, COLS - 1);
            else if (k == 1) len = COLS + 1;
            else             len = COLS;
            for (int c = 0; c < len; c++) begin
                sel = $urandom_range(0, 2);
                if (sel == 0)      q.push_back(CH_O);
                else if (sel == 1) q.push_back(CH_X);
                else               q.push_back(CH_DOT);
                if ($urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 1) q.push_back(CH_SP);
                    else                           q.push_back(CH_BAR);
                end
            end
            if ($urandom_range(0, 24) == 0) q.push_back(CH_BAD);
            if ($urandom_range(0, 3) == 0) q.push_back(CH_CR);
            q.push_back(CH_LF);
        end
        if ($urandom_range(0, 3) == 0) q.push_back(CH_DOT);
        return q;
    endfunction

    // Called at posedge+1; returns with the byte sampled and edge count in edge_cyc.
    task automatic send_byte(input u8 b, output int edge_cyc);
        host.uart_rd = 1'b1;
        host.uart_q  = b;
        @(posedge clk); #1;
        edge_cyc = cyc;
        host.uart_rd = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bq_t q, input bit byte_with_req, input int mid_req);
        int term;
        bit full;
        bit err;
        logic [N-1:0] a;
        logic [N-1:0] b;
        int v0;
        int e;
        int lf_cyc;
        model(q, term, full, err, a, b);
        if (err) begin a = '0; b = '0; end
        chk({tag, "/ready_idle"}, 32'(host.ready), 32'd1);
        chk({tag, "/hold_err"}, 32'(host.error_flag), 32'(last_err));
        chk({tag, "/hold_a"}, 32'(host.board_a_out), 32'(last_a));
        chk({tag, "/hold_b"}, 32'(host.board_b_out), 32'(last_b));
        host.req = 1'b1;
        if (byte_with_req) begin
            host.uart_rd = 1'b1;
            host.uart_q  = CH_O;
        end
        @(posedge clk); #1;
        host.req = 1'b0;
        host.uart_rd = 1'b0;
        v0 = vcount;
        chk({tag, "/busy"}, 32'(host.ready), 32'd0);
        chk({tag, "/err_clr"}, 32'(host.error_flag), 32'd0);
        lf_cyc = -100;
        foreach (q[i]) begin
            if (mid_req == i) begin
                host.req = 1'b1;
                @(posedge clk); #1;
                host.req = 1'b0;
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_byte(q[i], e);
            if (i == term) lf_cyc = e;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk({tag, "/valid_cnt"}, 32'(vcount - v0), 32'd1);
        chk({tag, "/latency"}, 32'(v_cyc), 32'(lf_cyc + (full ? 1 : 0)));
        chk({tag, "/err"}, 32'(v_err), 32'(err));
        chk({tag, "/a"}, 32'(v_a), 32'(a));
        chk({tag, "/b"}, 32'(v_b), 32'(b));
        chk({tag, "/ready_back"}, 32'(host.ready), 32'd1);
        last_a = a;
        last_b = b;
        last_err = err;
    endtask

    initial begin
        bq_t q;
        int v0;
        int e;
        string s1;
        s1 = "O.X\015\n.O.\015\nX..\015\n";
        host.req = 1'b0;
        host.uart_rd = 1'b0;
        host.uart_q = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst/ready", 32'(host.ready), 32'd1);
        chk("rst/valid", 32'(host.valid), 32'd0);
        chk("rst/err", 32'(host.error_flag), 32'd0);
        chk("rst/a", 32'(host.board_a_out), 32'd0);
        chk("rst/b", 32'(host.board_b_out), 32'd0);

        run_frame("s1", str2q(s1), 0, -1);
        chk("s1/a_fixed", 32'(last_a), 32'h011);
        chk("s1/b_fixed", 32'(last_b), 32'h044);
        run_frame("s2", str2q("O | . | X\n\n. O .\nX . .\n"), 0, -1);
        run_frame("s3", str2q("O.X\n.Z.\n..."), 0, -1);
        run_frame("s4short", str2q("OX\n"), 0, -1);
        run_frame("s4long", str2q("O.XO\n"), 0, -1);
        run_frame("s5", str2q("OOO\nO..\n...\n"), 0, -1);
        run_frame("req_byte", str2q(".O.\nX.O\n.X.\n"), 1, -1);
        run_frame("mid_req", str2q("O.X\n.O.\nX..\n"), 0, 4);

        // Reset in the middle of a parse: no valid pulse, everything back to zero.
        host.req = 1'b1;
        @(posedge clk); #1;
        host.req = 1'b0;
        v0 = vcount;
        q = str2q(s1);
        for (int i = 0; i < 5; i++) send_byte(q[i], e);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst/ready", 32'(host.ready), 32'd1);
        chk("midrst/no_valid", 32'(vcount - v0), 32'd0);
        chk("midrst/err", 32'(host.error_flag), 32'd0);
        chk("midrst/a", 32'(host.board_a_out), 32'd0);
        chk("midrst/b", 32'(host.board_b_out), 32'd0);
        last_a = '0;
        last_b = '0;
        last_err = 1'b0;

        for (int n = 0; n < 40; n++) begin
            run_frame($sformatf("rnd%0d", n), gen_frame(), 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
